// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply / divide unit producing a {hi,lo} result.
// Multiplies complete after MUL_STAGES cycles; divides use a restoring radix-2
// loop on operand magnitudes followed by one sign-correction cycle.
// Optional feature: define MULDIV_MADD_EN to enable madd/maddu/msub/msubu.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               op_ok;
  logic               accept;
  logic [2:0]         m_op;
  logic [WIDTH-1:0]   m_a, m_b;
  logic [2*WIDTH-1:0] mul_res;

`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] hilo_q, hilo_d;
  logic [2*WIDTH-1:0] m_hilo;
  assign op_ok = 1'b1;
`else
  logic unused_bits;
  assign op_ok       = ~op_i[2];
  assign unused_bits = ^{hilo_i, m_op[2:1]};
`endif

  assign accept = start_i & ~busy_q & ~annul_i & op_ok;

  // Absolute value of a possibly signed operand
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // One restoring-division step: returns {remainder, quotient shift register}
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh[WIDTH-1:0] - d;
    if (sh >= {1'b0, d}) return {diff, quo[WIDTH-2:0], 1'b1};
    else                 return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  // Full-width signed or unsigned product, modulo 2^(2*WIDTH)
  function automatic logic [2*WIDTH-1:0] mul_prod(input logic uns,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] ea, eb;
    ea = uns ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    eb = uns ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  // Multiply-path result: live inputs while idle (single-stage case), captured operands otherwise
  always_comb begin
    m_op    = (state_q == IDLE) ? op_i  : op_q;
    m_a     = (state_q == IDLE) ? opa_i : opa_q;
    m_b     = (state_q == IDLE) ? opb_i : opb_q;
    mul_res = mul_prod(m_op[0], m_a, m_b);
`ifdef MULDIV_MADD_EN
    m_hilo  = (state_q == IDLE) ? hilo_i : hilo_q;
    if (m_op[2]) mul_res = m_op[1] ? (m_hilo - mul_res) : (m_hilo + mul_res);
`endif
  end

  // Next-state and datapath control
  // The first quotient bit is produced on the accept edge so that WIDTH bits
  // plus the FIX cycle fit before DONE at T+WIDTH+1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    result_d = result_q;
`ifdef MULDIV_MADD_EN
    hilo_d   = hilo_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op_i;
          opa_d = opa_i;
          opb_d = opb_i;
`ifdef MULDIV_MADD_EN
          hilo_d = hilo_i;
`endif
          if (op_i[2:1] == 2'b01) begin
            if (opb_i == '0) begin
              state_d  = DONE;
              result_d = {opa_i, {WIDTH{1'b1}}};
              dbz_d    = 1'b1;
            end else begin
              state_d        = DIV;
              cnt_d          = CW'(1);
              opb_d          = mag(opb_i, ~op_i[0]);
              qneg_d         = ~op_i[0] & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
              rneg_d         = ~op_i[0] & opa_i[WIDTH-1];
              {rem_d, quo_d} = div_step('0, mag(opa_i, ~op_i[0]), mag(opb_i, ~op_i[0]));
            end
          end else if (MUL_STAGES == 1) begin
            state_d  = DONE;
            result_d = mul_res;
            dbz_d    = 1'b0;
          end else begin
            state_d = MUL;
            cnt_d   = CW'(1);
          end
        end
      end
      MUL: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MUL_STAGES - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = mul_res;
          dbz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          {rem_d, quo_d} = div_step(rem_q, quo_q, opb_q);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          result_d = {(rneg_q ? (~rem_q + 1'b1) : rem_q),
                      (qneg_q ? (~quo_q + 1'b1) : quo_q)};
          dbz_d    = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_MADD_EN
      hilo_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
`ifdef MULDIV_MADD_EN
      hilo_q   <= hilo_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule
